selector_scan_ctrl: RTL and testbench
=====================================

Name: selector_scan_ctrl

Overview:
- Sequences the 2-bit modulation and signal selectors of the waveform display mux. Changes are applied only on DAC sample-strobe boundaries.
- Manual mode: the selectors track the board switches.
- Auto mode: the block steps through all 16 {modulation, signal} pairs with a programmable dwell.
- After every selection change it waits a settle interval, then raises a capture request to the downstream frame-capture/scope block and holds it until acknowledged.

Parameters:
- DWELL_W, 24, width of the dwell-length input and dwell counter.
- SETTLE, 4, number of sample_en ticks to wait after a change before cap_req rises; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_en  in  1  single-cycle DAC sample strobe; all counting and selector updates are qualified by it.
- mode_auto  in  1  1 = auto scan, 0 = manual; synchronous level.
- sw_mod  in  2  manual modulation select (0 ASK, 1 FSK, 2 BPSK, 3 LFSR).
- sw_sig  in  2  manual signal select (0 sine, 1 cos, 2 saw, 3 square).
- next_btn  in  1  synchronized single-cycle pulse; skips the remaining dwell in auto mode.
- dwell_cycles  in  DWELL_W  dwell length in sample_en ticks; 0 is treated as 1.
- cap_ack  in  1  capture acknowledge from downstream.
- modulation_selector  out  2  registered selector to the display mux.
- signal_selector  out  2  registered selector to the display mux.
- scan_idx  out  4  equals {modulation_selector, signal_selector}.
- sel_changed  out  1  one-cycle pulse in the cycle after the selectors update.
- cap_req  out  1  capture request; level signal.
- cap_count  out  16  number of completed captures; wraps at 65535 -> 0.

Behaviour:
- Reset (async, active-high): all outputs 0, counters 0, state S_SETTLE. A capture of pair 0 is therefore taken after reset.
- State S_IDLE (manual):
  - On sample_en, if {sw_mod,sw_sig} != scan_idx: load the switches, go to S_SETTLE.
  - Else if mode_auto=1: clear the dwell counter, go to S_DWELL.
  - mode_auto is checked only when no switch difference exists; a switch change has priority.
- State S_SETTLE:
  - Count sample_en ticks. On the tick where the count reaches SETTLE: clear the count, go to S_REQ.
  - Selector and mode inputs are ignored.
- State S_REQ:
  - cap_req=1 for the whole state.
  - On cap_ack=1: cap_req drops next cycle, cap_count increments, go to S_DWELL if mode_auto else S_IDLE.
  - cap_req is never withdrawn without an ack, including when mode changes or next_btn fires.
  - cap_ack while cap_req=0 is ignored.
  - cap_ack in the same cycle cap_req first rises counts as the ack.
- State S_DWELL (auto):
  - Count sample_en ticks. The advance flag sets when the count reaches max(dwell_cycles,1) or on next_btn.
  - On the first sample_en with the advance flag set (the same cycle is allowed): scan_idx <= scan_idx+1 mod 16 (15 -> 0), clear the counter and flag, go to S_SETTLE.
  - If mode_auto=0 and no advance is pending: go to S_IDLE next cycle.
  - If an advance is pending, it completes first.
  - Auto scan resumes from the current selection, never from 0.
- next_btn outside S_DWELL is ignored and not queued.
- Selector outputs change only in cycles where sample_en=1, and only via the transitions above. sel_changed pulses exactly once per change.
- Latency:
  - Manual switch change -> selectors update on the next sample_en.
  - Selector change -> cap_req rises after SETTLE further sample_en ticks, 1 clk after the last tick.
- dwell_cycles is sampled live; reducing it below the current count causes an immediate advance.

Decomposition:
- Package display_pkg holds:
  - enum state_t {S_IDLE, S_SETTLE, S_REQ, S_DWELL};
  - modulation codes MOD_ASK..MOD_LFSR and signal codes SIG_SINE..SIG_SQU, shared with the display mux.
- No sub-module; one FSM plus three counters (settle, dwell, capture).

Test Plan:
- Reset release, mode_auto=0, switches 0, SETTLE=4, ack 2 clk after req -> cap_req high after the 4th sample_en; cap_count=1; state S_IDLE; selectors 0.
- Manual: sw_mod=2, sw_sig=3 -> on next sample_en scan_idx=4'hB, sel_changed 1 cycle; cap_req after 4 further ticks.
- Auto: dwell_cycles=3, ack immediate, start at idx 14 -> sequence 14, 15, 0, 1; each step 3 dwell + 4 settle ticks apart.
- next_btn mid-dwell (count 1 of 1000) -> advance on next sample_en. next_btn while cap_req=1 -> ignored, cap_req stays high until ack.
- mode_auto dropped while cap_req=1 and ack withheld 50 clk -> cap_req held 50 clk; then state S_IDLE and selectors unchanged.
- dwell_cycles=0 -> behaves as 1. Reset asserted during S_REQ -> cap_req=0 and selectors=0 asynchronously; cap_count=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the waveform display path: scan FSM states and
// the modulation/signal selector codes understood by the display mux.
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_REQ    = 2'd2,
    S_DWELL  = 2'd3
  } state_t;

  localparam logic [1:0] MOD_ASK  = 2'd0;
  localparam logic [1:0] MOD_FSK  = 2'd1;
  localparam logic [1:0] MOD_BPSK = 2'd2;
  localparam logic [1:0] MOD_LFSR = 2'd3;

  localparam logic [1:0] SIG_SINE = 2'd0;
  localparam logic [1:0] SIG_COS  = 2'd1;
  localparam logic [1:0] SIG_SAW  = 2'd2;
  localparam logic [1:0] SIG_SQU  = 2'd3;

  // Auto scan order is plain {modulation, signal} counting, wrapping 15 -> 0.
  function automatic logic [3:0] next_scan(input logic [3:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/selector_scan_ctrl.sv
// Selector sequencer for the display mux: manual tracking or auto scan of all
// 16 {modulation, signal} pairs, with a settle delay and capture handshake.
module selector_scan_ctrl
  import display_pkg::*;
#(
  parameter int DWELL_W = 24,
  parameter int SETTLE  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic               mode_auto,
  input  logic [1:0]         sw_mod,
  input  logic [1:0]         sw_sig,
  input  logic               next_btn,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               cap_ack,
  output logic [1:0]         modulation_selector,
  output logic [1:0]         signal_selector,
  output logic [3:0]         scan_idx,
  output logic               sel_changed,
  output logic               cap_req,
  output logic [15:0]        cap_count
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t             state;
  logic [3:0]         idx;
  logic [7:0]         settle_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               adv_flag;
  logic               sel_chg;
  logic [15:0]        cap_cnt;

  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W-1:0] dwell_nxt;
  logic               adv_hit;
  logic [3:0]         sw_idx;

  // Advance condition is evaluated against the live dwell length so that a
  // shortened dwell takes effect at once.
  always_comb begin
    sw_idx    = {sw_mod, sw_sig};
    dwell_eff = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    dwell_nxt = dwell_cnt + (sample_en ? DWELL_W'(1) : '0);
    adv_hit   = adv_flag | next_btn | (dwell_nxt >= dwell_eff);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_SETTLE;
      idx        <= '0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      adv_flag   <= 1'b0;
      sel_chg    <= 1'b0;
      cap_cnt    <= '0;
    end else begin
      sel_chg <= 1'b0;
      case (state)
        S_IDLE: begin
          // A switch difference wins over entering auto scan.
          if (sample_en) begin
            if (sw_idx != idx) begin
              idx        <= sw_idx;
              sel_chg    <= 1'b1;
              settle_cnt <= '0;
              state      <= S_SETTLE;
            end else if (mode_auto) begin
              dwell_cnt <= '0;
              adv_flag  <= 1'b0;
              state     <= S_DWELL;
            end
          end
        end
        S_SETTLE: begin
          if (sample_en) begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= S_REQ;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end
        S_REQ: begin
          // Request is held until acknowledged, whatever the mode does.
          if (cap_ack) begin
            cap_cnt   <= cap_cnt + 16'd1;
            dwell_cnt <= '0;
            adv_flag  <= 1'b0;
            state     <= mode_auto ? S_DWELL : S_IDLE;
          end
        end
        S_DWELL: begin
          if (sample_en && adv_hit) begin
            idx        <= next_scan(idx);
            sel_chg    <= 1'b1;
            dwell_cnt  <= '0;
            adv_flag   <= 1'b0;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else begin
            dwell_cnt <= dwell_nxt;
            adv_flag  <= adv_hit;
            if (!mode_auto && !adv_hit) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign modulation_selector = idx[3:2];
  assign signal_selector     = idx[1:0];
  assign scan_idx            = idx;
  assign sel_changed         = sel_chg;
  assign cap_req             = (state == S_REQ);
  assign cap_count           = cap_cnt;

endmodule

// File: tb/tb_selector_scan_ctrl.sv
// Directed bench for selector_scan_ctrl: reset capture, manual tracking,
// auto scan with wrap, next_btn, mode drop during a request, zero dwell, reset.
module tb_selector_scan_ctrl;
  import display_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic        mode_auto;
  logic [1:0]  sw_mod;
  logic [1:0]  sw_sig;
  logic        next_btn;
  logic [23:0] dwell_cycles;
  logic        cap_ack;
  logic [1:0]  modulation_selector;
  logic [1:0]  signal_selector;
  logic [3:0]  scan_idx;
  logic        sel_changed;
  logic        cap_req;
  logic [15:0] cap_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  selector_scan_ctrl #(.DWELL_W(24), .SETTLE(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .sample_en           (sample_en),
    .mode_auto           (mode_auto),
    .sw_mod              (sw_mod),
    .sw_sig              (sw_sig),
    .next_btn            (next_btn),
    .dwell_cycles        (dwell_cycles),
    .cap_ack             (cap_ack),
    .modulation_selector (modulation_selector),
    .signal_selector     (signal_selector),
    .scan_idx            (scan_idx),
    .sel_changed         (sel_changed),
    .cap_req             (cap_req),
    .cap_count           (cap_count)
  );

  task automatic cyc(input logic se);
    sample_en = se;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  // Four settle ticks, a hold period in S_REQ, then one acknowledge.
  task automatic settle_and_ack(input string tag, input int hold, input logic btn);
    logic [3:0] idx0;
    logic       exp_req;
    idx0 = scan_idx;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1);
      exp_req = (i == 4) ? 1'b1 : 1'b0;
      checks++;
      if (cap_req !== exp_req) begin
        errors++;
        $display("FAIL %s settle tick %0d: cap_req=%0b expected %0b", tag, i, cap_req, exp_req);
      end
      if (i < 4) gap(3);
    end
    for (int i = 0; i < hold; i++) begin
      next_btn = btn && (i == 0);
      cyc((i % 4) == 3);
      next_btn = 1'b0;
      checks++;
      if (cap_req !== 1'b1 || scan_idx !== idx0) begin
        errors++;
        $display("FAIL %s hold cycle %0d: cap_req=%0b idx=%0h expected 1 idx=%0h",
                 tag, i, cap_req, scan_idx, idx0);
      end
    end
    cap_ack = 1'b1;
    cyc(1'b0);
    cap_ack = 1'b0;
    exp_count++;
    checks++;
    if (cap_req !== 1'b0) begin
      errors++;
      $display("FAIL %s after ack: cap_req=%0b expected 0", tag, cap_req);
    end
    checks++;
    if (cap_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL %s cap_count: got %0d expected %0d", tag, cap_count, exp_count);
    end
    gap(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gap(3);
    checks++;
    if (scan_idx !== 4'h0 || cap_req !== 1'b0 || cap_count !== 16'd0 || sel_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: idx=%0h req=%0b count=%0d chg=%0b expected all 0",
               scan_idx, cap_req, cap_count, sel_changed);
    end
    reset = 1'b0;
    settle_and_ack("reset_capture", 2, 1'b0);
    checks++;
    if (dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_idle_state: state=%0d expected %0d", dut.state, S_IDLE);
    end
    checks++;
    if (modulation_selector !== 2'd0 || signal_selector !== 2'd0) begin
      errors++;
      $display("FAIL reset_selectors: mod=%0d sig=%0d expected 0 0", modulation_selector, signal_selector);
    end
  endtask

  task automatic test_manual();
    cyc(1'b1);
    checks++;
    if (sel_changed !== 1'b0 || scan_idx !== 4'h0) begin
      errors++;
      $display("FAIL manual_nochange: chg=%0b idx=%0h expected 0 0", sel_changed, scan_idx);
    end
    gap(3);
    sw_mod = MOD_BPSK;
    sw_sig = SIG_SQU;
    cyc(1'b0);
    checks++;
    if (scan_idx !== 4'h0) begin
      errors++;
      $display("FAIL manual_wait_strobe: idx=%0h expected 0", scan_idx);
    end
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'hB || modulation_selector !== 2'd2 || signal_selector !== 2'd3 || sel_changed !== 1'b1) begin
      errors++;
      $display("FAIL manual_load: idx=%0h mod=%0d sig=%0d chg=%0b expected b 2 3 1",
               scan_idx, modulation_selector, signal_selector, sel_changed);
    end
    cyc(1'b0);
    checks++;
    if (sel_changed !== 1'b0) begin
      errors++;
      $display("FAIL manual_pulse_width: chg=%0b expected 0", sel_changed);
    end
    gap(2);
    settle_and_ack("manual_capture", 0, 1'b0);
  endtask

  task automatic test_auto();
    logic [3:0] seq [3];
    logic [3:0] prev;
    seq[0] = 4'hF; seq[1] = 4'h0; seq[2] = 4'h1;
    mode_auto = 1'b1;
    dwell_cycles = 24'd3;
    sw_mod = MOD_LFSR;
    sw_sig = SIG_SAW;
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'hE || sel_changed !== 1'b1) begin
      errors++;
      $display("FAIL auto_start: idx=%0h chg=%0b expected e 1", scan_idx, sel_changed);
    end
    gap(3);
    settle_and_ack("auto_start_capture", 0, 1'b0);
    prev = 4'hE;
    for (int s = 0; s < 3; s++) begin
      for (int k = 1; k <= 3; k++) begin
        cyc(1'b1);
        checks++;
        if (k < 3 && scan_idx !== prev) begin
          errors++;
          $display("FAIL auto_dwell step %0d tick %0d: idx=%0h expected %0h", s, k, scan_idx, prev);
        end else if (k == 3 && (scan_idx !== seq[s] || sel_changed !== 1'b1)) begin
          errors++;
          $display("FAIL auto_advance step %0d: idx=%0h chg=%0b expected %0h 1",
                   s, scan_idx, sel_changed, seq[s]);
        end
        gap(3);
      end
      settle_and_ack("auto_capture", 0, 1'b0);
      prev = seq[s];
    end
  endtask

  task automatic test_next_btn();
    dwell_cycles = 24'd1000;
    cyc(1'b1);
    gap(3);
    next_btn = 1'b1;
    cyc(1'b0);
    next_btn = 1'b0;
    checks++;
    if (scan_idx !== 4'h1) begin
      errors++;
      $display("FAIL next_btn_wait: idx=%0h expected 1", scan_idx);
    end
    gap(2);
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'h2 || sel_changed !== 1'b1) begin
      errors++;
      $display("FAIL next_btn_advance: idx=%0h chg=%0b expected 2 1", scan_idx, sel_changed);
    end
    gap(3);
    settle_and_ack("next_btn_in_req", 12, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1);
      checks++;
      if (scan_idx !== 4'h2) begin
        errors++;
        $display("FAIL next_btn_not_queued tick %0d: idx=%0h expected 2", k, scan_idx);
      end
      gap(3);
    end
  endtask

  task automatic test_mode_drop();
    dwell_cycles = 24'd1;
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'h3 || sel_changed !== 1'b1) begin
      errors++;
      $display("FAIL live_dwell_reduce: idx=%0h chg=%0b expected 3 1", scan_idx, sel_changed);
    end
    gap(3);
    mode_auto = 1'b0;
    settle_and_ack("mode_drop", 50, 1'b0);
    checks++;
    if (dut.state !== S_IDLE || scan_idx !== 4'h3) begin
      errors++;
      $display("FAIL mode_drop_idle: state=%0d idx=%0h expected %0d 3", dut.state, scan_idx, S_IDLE);
    end
    sw_mod = MOD_ASK;
    sw_sig = SIG_SQU;
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'h3 || sel_changed !== 1'b0 || dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL manual_hold: idx=%0h chg=%0b state=%0d expected 3 0 %0d",
               scan_idx, sel_changed, dut.state, S_IDLE);
    end
    gap(3);
  endtask

  task automatic test_dwell_zero_and_reset();
    dwell_cycles = 24'd0;
    mode_auto = 1'b1;
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'h3 || sel_changed !== 1'b0) begin
      errors++;
      $display("FAIL dwell0_enter: idx=%0h chg=%0b expected 3 0", scan_idx, sel_changed);
    end
    gap(3);
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'h4 || sel_changed !== 1'b1) begin
      errors++;
      $display("FAIL dwell0_first: idx=%0h chg=%0b expected 4 1", scan_idx, sel_changed);
    end
    gap(3);
    settle_and_ack("dwell0_capture", 0, 1'b0);
    cyc(1'b1);
    checks++;
    if (scan_idx !== 4'h5) begin
      errors++;
      $display("FAIL dwell0_second: idx=%0h expected 5", scan_idx);
    end
    gap(3);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1);
      if (i < 4) gap(3);
    end
    checks++;
    if (cap_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req: cap_req=%0b expected 1", cap_req);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (cap_req !== 1'b0 || scan_idx !== 4'h0 || modulation_selector !== 2'd0 ||
        signal_selector !== 2'd0 || cap_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: req=%0b idx=%0h count=%0d expected 0 0 0", cap_req, scan_idx, cap_count);
    end
    mode_auto = 1'b0;
    sw_mod = MOD_ASK;
    sw_sig = SIG_SINE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_count = 0;
    settle_and_ack("post_reset_capture", 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    sample_en = 1'b0;
    mode_auto = 1'b0;
    sw_mod = 2'd0;
    sw_sig = 2'd0;
    next_btn = 1'b0;
    dwell_cycles = 24'd0;
    cap_ack = 1'b0;
    test_reset();
    test_manual();
    test_auto();
    test_next_btn();
    test_mode_drop();
    test_dwell_zero_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
